// File: rtl/ifetch_queue.sv
// Instruction fetch queue: a single-outstanding memory fetcher feeding a small
// FIFO of {pc, word} pairs, with branch redirect and in-flight response drop.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] m_addr,
    output logic        m_req,
    input  logic        m_ack,
    input  logic [31:0] m_data,
    output logic        i_valid,
    output logic [31:0] i_data,
    output logic [31:0] i_pc,
    input  logic        i_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic          m_req_q, m_req_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   word_mem_q [DEPTH];

    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_after_pop_s;
    logic [31:0]   redirect_pc_s;

    // Next-state, fetch pointer and FIFO bookkeeping.
    always_comb begin
        state_d           = state_q;
        fpc_d             = fpc_q;
        m_addr_d          = m_addr_q;
        push_s            = 1'b0;
        redirect_pc_s     = redirect_pc & 32'hFFFF_FFFC;
        pop_s             = i_ready && (count_q != {CW{1'b0}}) && !redirect;
        count_after_pop_s = count_q - {{AW{1'b0}}, pop_s};

        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fpc_d = redirect_pc_s;
                end else if (count_after_pop_s < DEPTH_C) begin
                    state_d  = ST_WAIT;
                    m_addr_d = fpc_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // A response arriving with the redirect is stale; drop it here.
                    fpc_d   = redirect_pc_s;
                    state_d = m_ack ? ST_IDLE : ST_DROP;
                end else if (m_ack) begin
                    push_s   = 1'b1;
                    fpc_d    = fpc_q + 32'd4;
                    m_addr_d = fpc_q + 32'd4;
                    // Keep one slot free for the next outstanding request.
                    if ((count_after_pop_s + {{AW{1'b0}}, 1'b1}) < DEPTH_C) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    fpc_d = redirect_pc_s;
                end else begin
                    fpc_d = fpc_q;
                end
                if (m_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        m_req_d = (state_d != ST_IDLE);

        if (redirect) begin
            count_d  = {CW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
        end else begin
            count_d  = count_after_pop_s + {{AW{1'b0}}, push_s};
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop_s};
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_s};
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fpc_q    <= RESET_PC;
            m_addr_q <= RESET_PC;
            m_req_q  <= 1'b0;
            count_q  <= {CW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            m_addr_q <= m_addr_d;
            m_req_q  <= m_req_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage; the head is always read from these registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                pc_mem_q[k]   <= 32'h0;
                word_mem_q[k] <= 32'h0;
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= fpc_q;
            word_mem_q[wr_ptr_q] <= m_data;
        end else begin
            pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
            word_mem_q[wr_ptr_q] <= word_mem_q[wr_ptr_q];
        end
    end

    assign m_addr  = m_addr_q;
    assign m_req   = m_req_q;
    assign i_valid = (count_q != {CW{1'b0}});
    assign i_data  = word_mem_q[rd_ptr_q];
    assign i_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue (DEPTH=4, RESET_PC=0).
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] m_addr;
    logic        m_req;
    logic        m_ack;
    logic [31:0] m_data;
    logic        i_valid;
    logic [31:0] i_data;
    logic [31:0] i_pc;
    logic        i_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks;
    int errors;
    int acks;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_addr      (m_addr),
        .m_req       (m_req),
        .m_ack       (m_ack),
        .m_data      (m_data),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_pc        (i_pc),
        .i_ready     (i_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5C3_0000) + 32'h0000_1001;
    endfunction

    assign m_data = m_ack ? mem_word(m_addr) : 32'hDEAD_BEEF;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count accepted acks (m_req && m_ack at the edge) over n edges.
    task automatic step_count(input int n);
        for (int k = 0; k < n; k++) begin
            if (m_req && m_ack) acks++;
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; acks = 0;
        reset = 1'b1; m_ack = 1'b0; i_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        #2;
        check_eq("rst_m_req",   {31'd0, m_req},   32'd0);
        check_eq("rst_i_valid", {31'd0, i_valid}, 32'd0);
        check_eq("rst_m_addr",  m_addr, 32'h0);
        check_eq("rst_i_data",  i_data, 32'h0);
        check_eq("rst_i_pc",    i_pc,   32'h0);
        step();
        reset = 1'b0;

        // First edge after release raises the request.
        step();
        check_eq("first_req",  {31'd0, m_req}, 32'd1);
        check_eq("first_addr", m_addr, 32'h0);

        // Streaming with ack and ready every cycle.
        m_ack = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("stream_valid", {31'd0, i_valid}, 32'd1);
            check_eq("stream_pc",    i_pc,   32'(4 * k));
            check_eq("stream_data",  i_data, mem_word(32'(4 * k)));
        end
        m_ack = 1'b0; i_ready = 1'b0;

        // Backpressure: exactly DEPTH acks, then idle.
        do_reset();
        m_ack = 1'b1;
        acks = 0;
        step_count(10);
        check_eq("bp_acks",  acks, 32'd4);
        check_eq("bp_idle",  {31'd0, m_req}, 32'd0);
        check_eq("bp_head",  i_pc, 32'h0);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check_eq("bp_pop_head", i_pc, 32'h4);
        check_eq("bp_pop_req",  {31'd0, m_req}, 32'd1);
        check_eq("bp_pop_addr", m_addr, 32'h10);
        acks = 0;
        step_count(5);
        check_eq("bp_one_more", acks, 32'd1);
        check_eq("bp_idle2",    {31'd0, m_req}, 32'd0);
        m_ack = 1'b0; i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("bp_drain_pc", i_pc, 32'(4 * k));
            step();
        end
        check_eq("bp_empty", {31'd0, i_valid}, 32'd0);
        i_ready = 1'b0;

        // Redirect while a request at 0x8 is pending.
        do_reset();
        step();
        m_ack = 1'b1;
        step();
        step();
        m_ack = 1'b0;
        check_eq("rd_pend_addr", m_addr, 32'h8);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check_eq("rd_drop_req",   {31'd0, m_req},   32'd1);
        check_eq("rd_drop_addr",  m_addr, 32'h8);
        check_eq("rd_flush",      {31'd0, i_valid}, 32'd0);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check_eq("rd_discard_valid", {31'd0, i_valid}, 32'd0);
        check_eq("rd_discard_req",   {31'd0, m_req},   32'd0);
        step();
        check_eq("rd_new_addr", m_addr, 32'h100);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check_eq("rd_head_pc",   i_pc,   32'h100);
        check_eq("rd_head_data", i_data, mem_word(32'h100));

        // Redirect with ack and ready on the same edge.
        redirect = 1'b1; redirect_pc = 32'h200; m_ack = 1'b1; i_ready = 1'b1;
        step();
        redirect = 1'b0; m_ack = 1'b0; i_ready = 1'b0;
        check_eq("sim_no_push", {31'd0, i_valid}, 32'd0);
        check_eq("sim_idle",    {31'd0, m_req},   32'd0);
        step();
        check_eq("sim_addr", m_addr, 32'h200);

        // Address wrap and ignored low bits of redirect_pc.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; m_ack = 1'b1;
        step();
        redirect = 1'b0;
        m_ack = 1'b0;
        step();
        check_eq("wrap_addr", m_addr, 32'hFFFF_FFFC);
        m_ack = 1'b1;
        step();
        check_eq("wrap_pc0", i_pc, 32'hFFFF_FFFC);
        step();
        m_ack = 1'b0;
        check_eq("wrap_next_addr", m_addr, 32'h4);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check_eq("wrap_pc1",   i_pc,   32'h0);
        check_eq("wrap_data1", i_data, mem_word(32'h0));
        redirect = 1'b1; redirect_pc = 32'h103; m_ack = 1'b1;
        step();
        redirect = 1'b0; m_ack = 1'b0;
        step();
        check_eq("lowbits_addr", m_addr, 32'h100);

        // Async reset in WAIT, then a stray ack after release.
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check_eq("ar_pre_valid", {31'd0, i_valid}, 32'd1);
        reset = 1'b1;
        #2;
        check_eq("ar_req",   {31'd0, m_req},   32'd0);
        check_eq("ar_valid", {31'd0, i_valid}, 32'd0);
        step();
        m_ack = 1'b1;
        reset = 1'b0;
        step();
        m_ack = 1'b0;
        check_eq("ar_stray_valid", {31'd0, i_valid}, 32'd0);
        check_eq("ar_req_rise",    {31'd0, m_req},   32'd1);
        check_eq("ar_addr",        m_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
